// File: rtl/display_arbiter.sv
// ============================================================================
// Module   : display_arbiter
// Purpose  : Tick-paced arbiter between a normal and an alert display source,
//            with minimum grant hold and alert blinking, feeding a 7-seg driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_arbiter #(
    parameter int DIV   = 50000,
    parameter int HOLD  = 4,
    parameter int BLINK = 250
) (
    input  logic       clk_disp,
    input  logic       rst,
    input  logic       req_n,
    input  logic [6:0] n_u,
    input  logic [6:0] n_d,
    input  logic [6:0] n_e,
    input  logic [6:0] n_a,
    input  logic       req_a,
    input  logic [6:0] a_u,
    input  logic [6:0] a_d,
    input  logic [6:0] a_e,
    input  logic [6:0] a_a,
    output logic       tick,
    output logic [6:0] Unidades,
    output logic [6:0] Decenas,
    output logic [6:0] Estado,
    output logic [6:0] Actividad,
    output logic [1:0] grant
);

    localparam int DIV_W   = $clog2(DIV);
    localparam int HOLD_W  = (HOLD  > 1) ? $clog2(HOLD)  : 1;
    localparam int BLINK_W = (BLINK > 1) ? $clog2(BLINK) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK - 1);
    localparam logic [6:0]         BLANK      = 7'h7F;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_ALERT = 2'd2;

    logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
    logic               tick_q,      tick_d;
    logic [1:0]         state_q,     state_d;
    logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_on_q,  phase_on_d;
    logic [1:0]         grant_q,     grant_d;
    logic [6:0]         uni_q, uni_d, dec_q, dec_d, est_q, est_d, act_q, act_d;

    // State register
    always_ff @(posedge clk_disp) begin
        if (rst) begin
            div_cnt_q   <= '0;
            tick_q      <= 1'b0;
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
            grant_q     <= 2'b00;
            uni_q       <= BLANK;
            dec_q       <= BLANK;
            est_q       <= BLANK;
            act_q       <= BLANK;
        end else begin
            div_cnt_q   <= div_cnt_d;
            tick_q      <= tick_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
            grant_q     <= grant_d;
            uni_q       <= uni_d;
            dec_q       <= dec_d;
            est_q       <= est_d;
            act_q       <= act_d;
        end
    end

    always_comb begin
        tick_d    = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick_d ? '0 : div_cnt_q + DIV_W'(1);
    end

    // Next-state: everything advances only during the registered tick cycle
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        blink_cnt_d = blink_cnt_q;
        phase_on_d  = phase_on_q;
        if (tick_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_a)      state_d = ST_ALERT;
                    else if (req_n) state_d = ST_NORM;
                end
                ST_NORM: begin
                    if (req_a)                            state_d = ST_ALERT;
                    else if (!req_n && hold_cnt_q == '0)  state_d = ST_IDLE;
                end
                ST_ALERT: begin
                    if (!req_a && hold_cnt_q == '0) state_d = req_n ? ST_NORM : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (state_d != state_q && state_d != ST_IDLE)
                hold_cnt_d = HOLD_LOAD;
            else if (hold_cnt_q != '0)
                hold_cnt_d = hold_cnt_q - HOLD_W'(1);

            if (state_d == ST_ALERT) begin
                if (state_q != ST_ALERT) begin
                    blink_cnt_d = '0;
                    phase_on_d  = 1'b1;
                end else if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    phase_on_d  = !phase_on_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                end
            end
        end
    end

    // Output: source chosen by the next state so codes and grant move together
    always_comb begin
        grant_d = grant_q;
        uni_d   = uni_q;
        dec_d   = dec_q;
        est_d   = est_q;
        act_d   = act_q;
        if (tick_q) begin
            case (state_d)
                ST_NORM: begin
                    grant_d = 2'b01;
                    {uni_d, dec_d, est_d, act_d} = {n_u, n_d, n_e, n_a};
                end
                ST_ALERT: begin
                    grant_d = 2'b10;
                    if (phase_on_d) {uni_d, dec_d, est_d, act_d} = {a_u, a_d, a_e, a_a};
                    else            {uni_d, dec_d, est_d, act_d} = {4{BLANK}};
                end
                default: begin
                    grant_d = 2'b00;
                    {uni_d, dec_d, est_d, act_d} = {4{BLANK}};
                end
            endcase
        end
    end

    assign tick      = tick_q;
    assign grant     = grant_q;
    assign Unidades  = uni_q;
    assign Decenas   = dec_q;
    assign Estado    = est_q;
    assign Actividad = act_q;

endmodule

`default_nettype wire

// File: tb/tb_display_arbiter.sv
// ============================================================================
// Module   : tb_display_arbiter
// Purpose  : Directed self-checking bench for display_arbiter (DIV=4,HOLD=3,BLINK=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_arbiter;

    localparam int DIV_P   = 4;
    localparam int HOLD_P  = 3;
    localparam int BLINK_P = 2;
    localparam logic [27:0] BLANK4 = {4{7'h7F}};

    logic       clk_disp;
    logic       rst;
    logic       req_n, req_a;
    logic [6:0] n_u, n_d, n_e, n_a;
    logic [6:0] a_u, a_d, a_e, a_a;
    logic       tick;
    logic [6:0] Unidades, Decenas, Estado, Actividad;
    logic [1:0] grant;

    int n_cmp = 0;
    int n_bad = 0;

    display_arbiter #(
        .DIV   (DIV_P),
        .HOLD  (HOLD_P),
        .BLINK (BLINK_P)
    ) dut (
        .clk_disp  (clk_disp),
        .rst       (rst),
        .req_n     (req_n),
        .n_u       (n_u),
        .n_d       (n_d),
        .n_e       (n_e),
        .n_a       (n_a),
        .req_a     (req_a),
        .a_u       (a_u),
        .a_d       (a_d),
        .a_e       (a_e),
        .a_a       (a_a),
        .tick      (tick),
        .Unidades  (Unidades),
        .Decenas   (Decenas),
        .Estado    (Estado),
        .Actividad (Actividad),
        .grant     (grant)
    );

    initial clk_disp = 1'b0;
    always #5 clk_disp = ~clk_disp;

    // Returns at the negedge right after the edge that consumed the next tick.
    task automatic wait_update();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2 * DIV_P + 2 && !seen; k++) begin
            @(negedge clk_disp);
            if (tick) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL tick_timeout: tick stayed 0, required 1 within %0d cycles", 2 * DIV_P + 2);
        end
        @(negedge clk_disp);
    endtask

    task automatic test_reset();
        logic exp_t;
        rst = 1'b1; req_n = 1'b0; req_a = 1'b0;
        {n_u, n_d, n_e, n_a} = '0;
        {a_u, a_d, a_e, a_a} = '0;
        repeat (2) @(negedge clk_disp);
        n_cmp++;
        if ({tick, grant, Unidades, Decenas, Estado, Actividad} !== {1'b0, 2'b00, BLANK4}) begin
            n_bad++;
            $display("FAIL reset_state: got tick=%b grant=%b codes=%h, want 0/00/%h",
                     tick, grant, {Unidades, Decenas, Estado, Actividad}, BLANK4);
        end
        rst = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk_disp);
            exp_t = (k % DIV_P == 0);
            n_cmp++;
            if (tick !== exp_t) begin
                n_bad++;
                $display("FAIL idle_tick_c%0d: got %b want %b", k, tick, exp_t);
            end
            n_cmp++;
            if ({grant, Unidades, Decenas, Estado, Actividad} !== {2'b00, BLANK4}) begin
                n_bad++;
                $display("FAIL idle_out_c%0d: got grant=%b codes=%h want 00/%h",
                         k, grant, {Unidades, Decenas, Estado, Actividad}, BLANK4);
            end
        end
    endtask

    task automatic test_norm();
        req_n = 1'b1;
        {n_u, n_d, n_e, n_a} = {7'h01, 7'h02, 7'h03, 7'h04};
        wait_update();
        n_cmp++;
        if (grant !== 2'b01) begin
            n_bad++;
            $display("FAIL norm_grant: got %b want 01", grant);
        end
        n_cmp++;
        if ({Unidades, Decenas, Estado, Actividad} !== {7'h01, 7'h02, 7'h03, 7'h04}) begin
            n_bad++;
            $display("FAIL norm_codes: got %h want %h",
                     {Unidades, Decenas, Estado, Actividad}, {7'h01, 7'h02, 7'h03, 7'h04});
        end
        n_u = 7'h40;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_disp);
            n_cmp++;
            if (Unidades !== 7'h01) begin
                n_bad++;
                $display("FAIL norm_no_partial_%0d: got %h want 01", k, Unidades);
            end
        end
        wait_update();
        n_cmp++;
        if (Unidades !== 7'h40) begin
            n_bad++;
            $display("FAIL norm_reload: got %h want 40", Unidades);
        end
    endtask

    task automatic test_preempt();
        {a_u, a_d, a_e, a_a} = {7'h08, 7'h10, 7'h20, 7'h30};
        req_a = 1'b1;
        wait_update();
        n_cmp++;
        if ({grant, Unidades} !== {2'b10, 7'h08}) begin
            n_bad++;
            $display("FAIL preempt: got grant=%b uni=%h want 10/08", grant, Unidades);
        end
    endtask

    // One-tick alert pulse: ALERT must persist for HOLD ticks in total.
    task automatic test_alert_release(input logic next_req_n);
        logic [1:0]  exp_g;
        logic [27:0] exp_c;
        if (grant !== 2'b10) begin
            req_a = 1'b1;
            wait_update();
        end
        req_a = 1'b0;
        req_n = next_req_n;
        for (int t = 2; t <= 4; t++) begin
            wait_update();
            if (t < 4)           exp_g = 2'b10;
            else if (next_req_n) exp_g = 2'b01;
            else                 exp_g = 2'b00;
            if (t == 2)                       exp_c = {7'h08, 7'h10, 7'h20, 7'h30};
            else if (t == 4 && next_req_n)    exp_c = {7'h40, 7'h02, 7'h03, 7'h04};
            else                              exp_c = BLANK4;
            n_cmp++;
            if (grant !== exp_g) begin
                n_bad++;
                $display("FAIL release_n%0b_t%0d_grant: got %b want %b", next_req_n, t, grant, exp_g);
            end
            n_cmp++;
            if ({Unidades, Decenas, Estado, Actividad} !== exp_c) begin
                n_bad++;
                $display("FAIL release_n%0b_t%0d_codes: got %h want %h",
                         next_req_n, t, {Unidades, Decenas, Estado, Actividad}, exp_c);
            end
        end
    endtask

    task automatic test_blink();
        logic [27:0] exp_c;
        req_n = 1'b0;
        req_a = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            wait_update();
            exp_c = (t == 3 || t == 4) ? BLANK4 : {7'h08, 7'h10, 7'h20, 7'h30};
            n_cmp++;
            if ({grant, Unidades, Decenas, Estado, Actividad} !== {2'b10, exp_c}) begin
                n_bad++;
                $display("FAIL blink_t%0d: got grant=%b codes=%h want 10/%h",
                         t, grant, {Unidades, Decenas, Estado, Actividad}, exp_c);
            end
        end
    endtask

    task automatic test_reset_mid_alert();
        logic exp_t;
        req_n = 1'b1;
        rst = 1'b1;
        @(negedge clk_disp);
        rst = 1'b0;
        n_cmp++;
        if ({tick, grant, Unidades, Decenas, Estado, Actividad} !== {1'b0, 2'b00, BLANK4}) begin
            n_bad++;
            $display("FAIL midreset_state: got tick=%b grant=%b codes=%h want 0/00/%h",
                     tick, grant, {Unidades, Decenas, Estado, Actividad}, BLANK4);
        end
        for (int k = 1; k <= DIV_P; k++) begin
            @(negedge clk_disp);
            exp_t = (k == DIV_P);
            n_cmp++;
            if (tick !== exp_t) begin
                n_bad++;
                $display("FAIL midreset_tick_c%0d: got %b want %b", k, tick, exp_t);
            end
        end
        @(negedge clk_disp);
        n_cmp++;
        if ({grant, Unidades} !== {2'b10, 7'h08}) begin
            n_bad++;
            $display("FAIL both_req_alert_wins: got grant=%b uni=%h want 10/08", grant, Unidades);
        end
    endtask

    initial begin
        test_reset();
        test_norm();
        test_preempt();
        test_alert_release(1'b1);
        test_alert_release(1'b0);
        test_blink();
        test_reset_mid_alert();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
